sprite_draw_datapath: RTL and testbench

SPRITE_DRAW_DATAPATH -- requirements
Module: sprite_draw_datapath

---
 rtl/sprite_draw_datapath.sv | 188 ++++++++++++++++++
 tb/tb_sprite_draw_datapath.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/sprite_draw_datapath.sv
// Sprite draw datapath: scans a bird (4x4) or wall (8x120) rectangle one pixel per
// cycle into registered VGA x/y/colour/plot, then pulses flag for the controller.
module sprite_draw_datapath (
    input  logic       clk,
    input  logic       resetn,
    input  logic [3:0] cur_state,
    input  logic       cmd_valid,
    input  logic [6:0] bird_y,
    input  logic [7:0] wall_x,
    input  logic [6:0] gap_y,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic [2:0] colour,
    output logic       plot,
    output logic       flag,
    output logic       busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [3:0] CMD_ERASE_BIRD = 4'b0001;
    localparam logic [3:0] CMD_DRAW_BIRD  = 4'b0010;
    localparam logic [3:0] CMD_ERASE_WALL = 4'b0011;
    localparam logic [3:0] CMD_DRAW_WALL  = 4'b0100;

    function automatic logic is_bird_cmd(input logic [3:0] cmd);
        return (cmd == CMD_ERASE_BIRD) || (cmd == CMD_DRAW_BIRD);
    endfunction

    function automatic logic is_wall_cmd(input logic [3:0] cmd);
        return (cmd == CMD_ERASE_WALL) || (cmd == CMD_DRAW_WALL);
    endfunction

    function automatic logic [2:0] colour_of(input logic [3:0] cmd);
        logic [2:0] c;
        case (cmd)
            CMD_DRAW_BIRD: c = 3'b110;
            CMD_DRAW_WALL: c = 3'b010;
            default:       c = 3'b000;
        endcase
        return c;
    endfunction

    state_t      state_r;
    state_t      state_s;
    logic [3:0]  cmd_r;
    logic [7:0]  base_x_r;
    logic [6:0]  base_y_r;
    logic [6:0]  gap_r;
    logic [2:0]  col_r;
    logic [6:0]  row_r;

    logic        accept_s;
    logic        wall_s;
    logic [2:0]  col_max_s;
    logic [6:0]  row_max_s;
    logic        last_s;
    logic [8:0]  px_s;
    logic [8:0]  py_s;
    logic [7:0]  gap_lo_s;
    logic [7:0]  gap_hi_s;
    logic        in_gap_s;
    logic        pix_on_s;

    assign accept_s = (state_r == ST_IDLE) && cmd_valid;

    // Pixel geometry for the latched command and the current scan position
    always_comb begin
        wall_s    = is_wall_cmd(cmd_r);
        col_max_s = wall_s ? 3'd7 : 3'd3;
        row_max_s = wall_s ? 7'd119 : 7'd3;
        last_s    = (col_r == col_max_s) && (row_r == row_max_s);
        px_s      = {1'b0, base_x_r} + {6'b000000, col_r};
        py_s      = {2'b00, base_y_r} + {2'b00, row_r};
        // 8-bit gap bounds so a gap running past row 119 clips instead of wrapping
        gap_lo_s  = {1'b0, gap_r};
        gap_hi_s  = gap_lo_s + 8'd32;
        in_gap_s  = wall_s && (py_s[7:0] >= gap_lo_s) && (py_s[7:0] < gap_hi_s);
        pix_on_s  = (px_s <= 9'd159) && (py_s <= 9'd119) && !in_gap_s;
    end

    // Next-state logic; NOP codes skip the scan entirely
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    if (is_bird_cmd(cur_state) || is_wall_cmd(cur_state)) begin
                        state_s = ST_SCAN;
                    end else begin
                        state_s = ST_DONE;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SCAN: begin
                if (last_s) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_SCAN;
                end
            end
            ST_DONE: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Command latch: inputs are frozen at accept for the whole command
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cmd_r    <= 4'd0;
            base_x_r <= 8'd0;
            base_y_r <= 7'd0;
            gap_r    <= 7'd0;
        end else if (accept_s) begin
            cmd_r    <= cur_state;
            base_x_r <= is_bird_cmd(cur_state) ? 8'd40 : wall_x;
            base_y_r <= is_bird_cmd(cur_state) ? bird_y : 7'd0;
            gap_r    <= gap_y;
        end
    end

    // Row-major scan counters, x inner
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            col_r <= 3'd0;
            row_r <= 7'd0;
        end else if (accept_s) begin
            col_r <= 3'd0;
            row_r <= 7'd0;
        end else if (state_r == ST_SCAN) begin
            if (col_r == col_max_s) begin
                col_r <= 3'd0;
                row_r <= row_r + 7'd1;
            end else begin
                col_r <= col_r + 3'd1;
            end
        end
    end

    // Registered VGA and handshake outputs
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            x      <= 8'd0;
            y      <= 7'd0;
            colour <= 3'd0;
            plot   <= 1'b0;
            flag   <= 1'b0;
            busy   <= 1'b0;
        end else begin
            case (state_r)
                ST_SCAN: begin
                    x      <= px_s[7:0];
                    y      <= py_s[6:0];
                    colour <= colour_of(cmd_r);
                    plot   <= pix_on_s;
                    flag   <= 1'b0;
                    busy   <= 1'b1;
                end
                ST_DONE: begin
                    plot <= 1'b0;
                    flag <= 1'b1;
                    busy <= 1'b1;
                end
                default: begin
                    plot <= 1'b0;
                    flag <= 1'b0;
                    busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sprite_draw_datapath.sv
// Directed bench for sprite_draw_datapath: per-pixel checks of coordinates, colour,
// plot masking, flag/busy timing, mid-scan command rejection and reset abort.
module tb_sprite_draw_datapath;

    logic       clk;
    logic       resetn;
    logic [3:0] cur_state;
    logic       cmd_valid;
    logic [6:0] bird_y;
    logic [7:0] wall_x;
    logic [6:0] gap_y;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       plot;
    logic       flag;
    logic       busy;

    int tests_run_r;
    int tests_failed_r;

    sprite_draw_datapath dut (
        .clk       (clk),
        .resetn    (resetn),
        .cur_state (cur_state),
        .cmd_valid (cmd_valid),
        .bird_y    (bird_y),
        .wall_x    (wall_x),
        .gap_y     (gap_y),
        .x         (x),
        .y         (y),
        .colour    (colour),
        .plot      (plot),
        .flag      (flag),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run_r++;
        if (obs !== exp) begin
            tests_failed_r++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".x"}, 32'(x), 32'd0);
        check({tag, ".y"}, 32'(y), 32'd0);
        check({tag, ".colour"}, 32'(colour), 32'd0);
        check({tag, ".plot"}, 32'(plot), 32'd0);
        check({tag, ".flag"}, 32'(flag), 32'd0);
        check({tag, ".busy"}, 32'(busy), 32'd0);
    endtask

    // Issue one command (entered #1 after an edge) and check every cycle of it.
    // mid: pixel index where a stray cmd_valid is pulsed (-1 none).
    // abort_at: pixel index where resetn is pulled low (-1 none).
    task automatic run_cmd(input string tag, input logic [3:0] code, input logic [6:0] by,
                           input logic [7:0] wx, input logic [6:0] gy, input int n_pix,
                           input int exp_plots, input int mid, input int abort_at);
        int  plots;
        int  cols;
        int  ex;
        int  ey;
        int  ecol;
        bit  wall;
        bit  eplot;
        plots = 0;
        wall  = (code == 4'b0011) || (code == 4'b0100);
        cols  = wall ? 8 : 4;
        case (code)
            4'b0010: ecol = 6;
            4'b0100: ecol = 2;
            default: ecol = 0;
        endcase
        cur_state = code;
        bird_y    = by;
        wall_x    = wx;
        gap_y     = gy;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cur_state = 4'b0100;
        bird_y    = 7'd60;
        wall_x    = 8'd3;
        gap_y     = 7'd0;
        for (int n = 0; n < n_pix; n++) begin
            if (n == abort_at) begin
                resetn = 1'b0;
                #1;
                check_all_zero({tag, ".abort"});
                for (int c = 0; c < 4; c++) begin
                    @(posedge clk);
                    #1;
                    check_all_zero({tag, ".held"});
                end
                resetn = 1'b1;
                return;
            end
            @(posedge clk);
            #1;
            cmd_valid = (n == mid) ? 1'b1 : 1'b0;
            if (n == mid) cur_state = 4'b0010;
            ex    = wall ? (int'(wx) + n % cols) : (40 + n % cols);
            ey    = wall ? (n / cols) : (int'(by) + n / cols);
            eplot = (ex <= 159) && (ey <= 119) &&
                    !(wall && (ey >= int'(gy)) && (ey < int'(gy) + 32));
            if (plot) plots++;
            check({tag, ".x"}, 32'(x), 32'(ex % 256));
            check({tag, ".y"}, 32'(y), 32'(ey % 128));
            check({tag, ".colour"}, 32'(colour), 32'(ecol));
            check({tag, ".plot"}, 32'(plot), 32'(eplot));
            check({tag, ".busy"}, 32'(busy), 32'd1);
            check({tag, ".flag_scan"}, 32'(flag), 32'd0);
        end
        cmd_valid = 1'b0;
        check({tag, ".plots"}, 32'(plots), 32'(exp_plots));
        @(posedge clk);
        #1;
        check({tag, ".flag"}, 32'(flag), 32'd1);
        check({tag, ".flag_plot"}, 32'(plot), 32'd0);
        check({tag, ".flag_busy"}, 32'(busy), 32'd1);
        @(posedge clk);
        #1;
        check({tag, ".post_flag"}, 32'(flag), 32'd0);
        check({tag, ".post_busy"}, 32'(busy), 32'd0);
        check({tag, ".post_plot"}, 32'(plot), 32'd0);
    endtask

    initial begin
        tests_run_r    = 0;
        tests_failed_r = 0;
        resetn    = 1'b0;
        cur_state = 4'd0;
        cmd_valid = 1'b0;
        bird_y    = 7'd0;
        wall_x    = 8'd0;
        gap_y     = 7'd0;
        #2;
        check_all_zero("reset");
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset_hold");
        resetn = 1'b1;
        // accepted on the first edge after release
        run_cmd("draw_bird10", 4'b0010, 7'd10, 8'd0, 7'd0, 16, 16, -1, -1);
        run_cmd("draw_wall100", 4'b0100, 7'd0, 8'd100, 7'd50, 960, 704, -1, -1);
        run_cmd("erase_wall156", 4'b0011, 7'd0, 8'd156, 7'd127, 960, 480, -1, -1);
        run_cmd("draw_bird118", 4'b0010, 7'd118, 8'd0, 7'd0, 16, 8, -1, -1);
        run_cmd("erase_bird", 4'b0001, 7'd20, 8'd0, 7'd0, 16, 16, -1, -1);
        run_cmd("nop", 4'b1001, 7'd10, 8'd10, 7'd10, 0, 0, -1, -1);
        run_cmd("wall_stray", 4'b0100, 7'd0, 8'd0, 7'd100, 960, 8 * 100, 123, -1);
        run_cmd("wall_abort", 4'b0100, 7'd0, 8'd20, 7'd10, 960, 0, -1, 300);
        run_cmd("bird_after", 4'b0010, 7'd50, 8'd0, 7'd0, 16, 16, -1, -1);
        repeat (2) @(posedge clk);
        #1;
        check("idle_flag", 32'(flag), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run_r, tests_failed_r);
        $finish;
    end

endmodule
